mem_access_seq: RTL and testbench

Memory access sequencer between the control unit and the data RAM. On a start pulse it latches the decoded W/B/D/L access attributes and the effective address. It then runs the RAM handshake (MFA out, MOC in) for one beat, or two beats for doubleword. It finishes with a one-cycle done pulse and captured read data. It replaces ad-hoc MFA driving in the control-unit state machine for every load/store and instruction fetch.

---
 rtl/mem_access_seq_pkg.sv | 36 +++
 rtl/mem_access_seq_timer.sv | 37 +++
 rtl/mem_access_seq.sv | 153 +++++++++++++++
 tb/tb_mem_access_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared encodings and helpers for the memory access sequencer.
// Optional feature macro used by the sequencer: MEM_SEQ_TIMEOUT_EN.
package mem_access_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        GAP   = 3'd2,
        BEAT1 = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Loads are zero-extended here; sign extension happens downstream.
    function automatic logic [31:0] zext_load(input logic [31:0] d, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return {24'd0, d[7:0]};
            SIZE_HALF: return {16'd0, d[15:0]};
            default:   return d;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SIZE_HALF: return a[0];
            SIZE_WORD: return (a != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_timer.sv
// mem_beat_timer: counts beat cycles with MOC low; only built with MEM_SEQ_TIMEOUT_EN.
// Clears whenever the sequencer is outside a beat, so each beat starts from zero.
module mem_beat_timer
    import mem_access_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_beat,
    input  logic moc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (in_beat && !moc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the cycle that would make the count reach TIMEOUT_CYCLES.
    assign expired = in_beat && !moc && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: latches a decoded access on start, runs one or two MFA/MOC beats, ends with done.
// Define MEM_SEQ_TIMEOUT_EN to add a per-beat MOC timeout reported through err.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        W,
    input  logic        B,
    input  logic        D,
    input  logic        L,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_lo,
    output logic [31:0] rdata_hi,
    output logic        mem_mfa,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_moc
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        rw_q, rw_d;
    logic        dbl_q, dbl_d;
    logic        err_q, err_d;
    logic [31:0] wlo_q, wlo_d;
    logic [31:0] whi_q, whi_d;
    logic [31:0] rlo_q, rlo_d;
    logic [31:0] rhi_q, rhi_d;
    logic [1:0]  req_size;
    logic        timeout_hit;

    // Doubleword wins over the other attributes since it always means word beats.
    always_comb begin
        if (D)      req_size = SIZE_WORD;
        else if (B) req_size = SIZE_BYTE;
        else if (W) req_size = SIZE_WORD;
        else        req_size = SIZE_HALF;
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    mem_beat_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_beat (mem_mfa),
        .moc     (mem_moc),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rw_d    = rw_q;
        dbl_d   = dbl_q;
        err_d   = err_q;
        wlo_d   = wlo_q;
        whi_d   = whi_q;
        rlo_d   = rlo_q;
        rhi_d   = rhi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr;
                    size_d  = req_size;
                    rw_d    = L;
                    dbl_d   = D;
                    wlo_d   = wdata_lo;
                    whi_d   = wdata_hi;
                    err_d   = misaligned(req_size, addr[1:0]);
                    state_d = misaligned(req_size, addr[1:0]) ? FIN : BEAT0;
                end
            end
            BEAT0: begin
                if (mem_moc) begin
                    if (rw_q) rlo_d = zext_load(mem_rdata, size_q);
                    state_d = dbl_q ? GAP : FIN;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            GAP:   state_d = BEAT1;
            BEAT1: begin
                if (mem_moc) begin
                    if (rw_q) rhi_d = mem_rdata;
                    state_d = FIN;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            rw_q    <= 1'b0;
            dbl_q   <= 1'b0;
            err_q   <= 1'b0;
            wlo_q   <= '0;
            whi_q   <= '0;
            rlo_q   <= '0;
            rhi_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            dbl_q   <= dbl_d;
            err_q   <= err_d;
            wlo_q   <= wlo_d;
            whi_q   <= whi_d;
            rlo_q   <= rlo_d;
            rhi_q   <= rhi_d;
        end
    end

    // Bus outputs decode from registered state only, so they hold steady while MFA is high.
    assign mem_mfa   = (state_q == BEAT0) || (state_q == BEAT1);
    assign mem_addr  = (state_q == BEAT1) ? addr_q + 32'd4 : addr_q;
    assign mem_wdata = (state_q == BEAT1) ? whi_q : wlo_q;
    assign mem_rw    = rw_q;
    assign mem_size  = size_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign err       = done && err_q;
    assign rdata_lo  = rlo_q;
    assign rdata_hi  = rhi_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq; build with MEM_SEQ_TIMEOUT_EN to also exercise the timeout.
module tb_mem_access_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] addr;
    logic        W, B, D, L;
    logic [31:0] wdata_lo, wdata_hi;
    logic        busy, done, err;
    logic [31:0] rdata_lo, rdata_hi;
    logic        mem_mfa, mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_moc;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
        .W(W), .B(B), .D(D), .L(L),
        .wdata_lo(wdata_lo), .wdata_hi(wdata_hi),
        .busy(busy), .done(done), .err(err),
        .rdata_lo(rdata_lo), .rdata_hi(rdata_hi),
        .mem_mfa(mem_mfa), .mem_rw(mem_rw), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w, b, d, l,
                       input logic [31:0] lo, hi);
        start = 1'b1; addr = a; W = w; B = b; D = d; L = l;
        wdata_lo = lo; wdata_hi = hi;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; addr = '0; W = 0; B = 0; D = 0; L = 0;
        wdata_lo = '0; wdata_hi = '0; mem_rdata = '0; mem_moc = 1'b0;
        repeat (2) cyc();
        if ({mem_mfa, busy, done, err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {mem_mfa, busy, done, err});
        end
        n_cmp++;
        if ({mem_addr, rdata_lo, rdata_hi} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want zeros", mem_addr, rdata_lo, rdata_hi);
        end
        n_cmp++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_word_load();
        req(32'h100, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, mem_rw, mem_size, busy, done} !== 6'b111010 || mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL wl_beat: got %b addr %h want 111010 addr 100",
                               {mem_mfa, mem_rw, mem_size, busy, done}, mem_addr);
        end
        n_cmp++;
        cyc();
        mem_moc = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc(); mem_moc = 1'b0; mem_rdata = '0;
        if ({mem_mfa, busy, done, err} !== 4'b0110 || rdata_lo !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wl_done: got %b rdata %h want 0110 rdata deadbeef",
                               {mem_mfa, busy, done, err}, rdata_lo);
        end
        n_cmp++;
        cyc();
        if ({mem_mfa, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL wl_idle: got %b want 000", {mem_mfa, busy, done});
        end
        n_cmp++;
    endtask

    task automatic test_byte_store();
        req(32'h103, 0, 1, 0, 0, 32'h5A, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, mem_rw, mem_size} !== 4'b1000 || mem_addr !== 32'h103 || mem_wdata !== 32'h5A) begin
            n_fail++; $display("FAIL bs_beat: got %b addr %h wdata %h want 1000 103 5a",
                               {mem_mfa, mem_rw, mem_size}, mem_addr, mem_wdata);
        end
        n_cmp++;
        mem_moc = 1'b1; mem_rdata = 32'h77777777;
        cyc(); mem_moc = 1'b0;
        if ({mem_mfa, done, err} !== 3'b010 || rdata_lo !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL bs_done: got %b rdata %h want 010 rdata deadbeef",
                               {mem_mfa, done, err}, rdata_lo);
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_half_load();
        req(32'h202, 0, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, mem_size} !== 3'b101) begin
            n_fail++; $display("FAIL hl_size: got %b want 101", {mem_mfa, mem_size});
        end
        n_cmp++;
        mem_moc = 1'b1; mem_rdata = 32'hFFFF8765;
        cyc(); mem_moc = 1'b0;
        if (done !== 1'b1 || rdata_lo !== 32'h00008765) begin
            n_fail++; $display("FAIL hl_zext: got done %b rdata %h want 1 00008765", done, rdata_lo);
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_dword_load();
        req(32'hFFFFFFFC, 0, 0, 1, 1, 32'hAAAA0000, 32'hBBBB1111);
        cyc(); start = 1'b0;
        if ({mem_mfa, mem_rw, mem_size} !== 4'b1110 || mem_addr !== 32'hFFFFFFFC) begin
            n_fail++; $display("FAIL dw_beat0: got %b addr %h want 1110 fffffffc",
                               {mem_mfa, mem_rw, mem_size}, mem_addr);
        end
        n_cmp++;
        mem_moc = 1'b1; mem_rdata = 32'h11112222;
        cyc();
        if ({mem_mfa, busy, done} !== 3'b010) begin
            n_fail++; $display("FAIL dw_gap: got %b want 010", {mem_mfa, busy, done});
        end
        n_cmp++;
        mem_rdata = 32'h0BAD0BAD;
        cyc(); mem_moc = 1'b0;
        if (mem_mfa !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hBBBB1111) begin
            n_fail++; $display("FAIL dw_beat1: got mfa %b addr %h wdata %h want 1 0 bbbb1111",
                               mem_mfa, mem_addr, mem_wdata);
        end
        n_cmp++;
        cyc();
        mem_moc = 1'b1; mem_rdata = 32'h33334444;
        cyc(); mem_moc = 1'b0;
        if ({done, err} !== 2'b10 || rdata_lo !== 32'h11112222 || rdata_hi !== 32'h33334444) begin
            n_fail++; $display("FAIL dw_done: got %b lo %h hi %h want 10 11112222 33334444",
                               {done, err}, rdata_lo, rdata_hi);
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_misaligned();
        req(32'h201, 0, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, busy, done, err} !== 4'b0111 || rdata_lo !== 32'h11112222) begin
            n_fail++; $display("FAIL mis_half: got %b rdata %h want 0111 11112222",
                               {mem_mfa, busy, done, err}, rdata_lo);
        end
        n_cmp++;
        cyc();
        req(32'h102, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, done, err} !== 3'b011) begin
            n_fail++; $display("FAIL mis_word: got %b want 011", {mem_mfa, done, err});
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_back_to_back();
        req(32'h500, 1, 0, 0, 0, 32'h12345678, 32'h0);
        cyc();
        addr = 32'h600;
        cyc(); start = 1'b0;
        if (mem_mfa !== 1'b1 || mem_addr !== 32'h500) begin
            n_fail++; $display("FAIL busy_start: got mfa %b addr %h want 1 500", mem_mfa, mem_addr);
        end
        n_cmp++;
        mem_moc = 1'b1;
        cyc(); mem_moc = 1'b0;
        req(32'h700, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        if ({mem_mfa, busy} !== 2'b00) begin
            n_fail++; $display("FAIL fin_start: got %b want 00", {mem_mfa, busy});
        end
        n_cmp++;
        req(32'h700, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        mem_moc = 1'b1; mem_rdata = 32'h01020304;
        if (mem_mfa !== 1'b1 || mem_addr !== 32'h700) begin
            n_fail++; $display("FAIL next_start: got mfa %b addr %h want 1 700", mem_mfa, mem_addr);
        end
        n_cmp++;
        cyc(); mem_moc = 1'b0;
        if (done !== 1'b1 || rdata_lo !== 32'h01020304) begin
            n_fail++; $display("FAIL min_lat: got done %b rdata %h want 1 01020304", done, rdata_lo);
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_reset_mid();
        req(32'h800, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        if ({mem_mfa, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL rst_async: got %b want 000", {mem_mfa, busy, done});
        end
        n_cmp++;
        cyc();
        if (done !== 1'b0 || rdata_lo !== 32'h0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_hold: got done %b rdata %h addr %h want 0 0 0", done, rdata_lo, mem_addr);
        end
        n_cmp++;
        rst_n = 1'b1;
        cyc();
        req(32'h900, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        mem_moc = 1'b1; mem_rdata = 32'hCAFEF00D;
        cyc(); mem_moc = 1'b0;
        if (done !== 1'b1 || rdata_lo !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL rst_resume: got done %b rdata %h want 1 cafef00d", done, rdata_lo);
        end
        n_cmp++;
        cyc();
    endtask

`ifdef MEM_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        req(32'hA00, 1, 0, 0, 1, 32'h0, 32'h0);
        cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ({mem_mfa, done} !== 2'b10) begin
                n_fail++; $display("FAIL to_wait%0d: got %b want 10", i, {mem_mfa, done});
            end
            n_cmp++;
            cyc();
        end
        if ({mem_mfa, done, err} !== 3'b011 || rdata_lo !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL to_fin: got %b rdata %h want 011 cafef00d", {mem_mfa, done, err}, rdata_lo);
        end
        n_cmp++;
        cyc();
        if ({mem_mfa, busy} !== 2'b00) begin
            n_fail++; $display("FAIL to_idle: got %b want 00", {mem_mfa, busy});
        end
        n_cmp++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_half_load();
        test_dword_load();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
